// File: rtl/iob_ram_sp_be_ctrl_if.sv
// Request/response channel and RAM-macro strobes for iob_ram_sp_be_ctrl.
// slave is the controller's view; master is the requester/RAM environment's view.
interface iob_ram_sp_be_ctrl_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic              req_valid_i;
   logic              req_ready_o;
   logic [ADDR_W-1:0] req_addr_i;
   logic [STRB_W-1:0] req_wstrb_i;
   logic [DATA_W-1:0] req_wdata_i;
   logic              rvalid_o;
   logic              rready_i;
   logic [DATA_W-1:0] rdata_o;
   logic              ram_en_o;
   logic [STRB_W-1:0] ram_we_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic [DATA_W-1:0] ram_d_o;
   logic [DATA_W-1:0] ram_d_i;

   modport slave (
      input  req_valid_i, req_addr_i, req_wstrb_i, req_wdata_i, rready_i, ram_d_i,
      output req_ready_o, rvalid_o, rdata_o, ram_en_o, ram_we_o, ram_addr_o, ram_d_o
   );

   modport master (
      output req_valid_i, req_addr_i, req_wstrb_i, req_wdata_i, rready_i, ram_d_i,
      input  req_ready_o, rvalid_o, rdata_o, ram_en_o, ram_we_o, ram_addr_o, ram_d_o
   );
endinterface

// File: rtl/iob_ram_sp_be_ctrl.sv
// Requester-side controller for a single-port byte-enable RAM: request-to-strobe
// conversion, 2-entry read response buffer and an address-sweeping clear FSM.
module iob_ram_sp_be_ctrl #(
   parameter int                ADDR_W   = 10,
   parameter int                DATA_W   = 32,
   parameter int                INIT_EN  = 1,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clear_i,
   output logic                busy_o,
   iob_ram_sp_be_ctrl_if.slave bus
);
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;
   logic              r_inflight;
   logic [1:0]        r_occ;
   logic              r_wptr;
   logic              r_rptr;
   logic [DATA_W-1:0] r_buf [2];

   logic              w_rvalid;
   logic              w_pop;
   logic              w_push;
   logic              w_room;
   logic              w_hs;
   logic              w_rd_hs;
   logic [2:0]        w_pending;

   // Room counts the read already in flight and credits a pop happening this cycle,
   // which gives back-to-back reads without overflowing the 2-entry buffer.
   assign w_rvalid  = (r_occ != 2'd0);
   assign w_pop     = w_rvalid & bus.rready_i;
   assign w_push    = r_inflight;
   assign w_pending = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
   assign w_room    = (w_pending < 3'd2);

   assign bus.rvalid_o = w_rvalid;
   assign bus.rdata_o  = w_rvalid ? r_buf[r_rptr] : '0;

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_hs            = 1'b0;
      w_rd_hs         = 1'b0;
      busy_o          = 1'b0;
      bus.req_ready_o = 1'b0;
      bus.ram_en_o    = 1'b0;
      bus.ram_we_o    = '0;
      bus.ram_addr_o  = '0;
      bus.ram_d_o     = '0;
      if (rst_i) begin
         busy_o = (INIT_EN != 0);
      end else begin
         case (r_state)
            S_CLEAR: begin
               busy_o         = 1'b1;
               bus.ram_en_o   = 1'b1;
               bus.ram_we_o   = {STRB_W{1'b1}};
               bus.ram_addr_o = r_cnt;
               bus.ram_d_o    = INIT_VAL;
               w_cnt_nxt      = r_cnt + ADDR_W'(1);
               if (r_cnt == {ADDR_W{1'b1}}) w_state_nxt = S_READY;
            end
            S_READY: begin
               bus.req_ready_o = w_room;
               w_hs            = bus.req_valid_i & w_room;
               if (w_hs) begin
                  bus.ram_en_o   = 1'b1;
                  bus.ram_we_o   = bus.req_wstrb_i;
                  bus.ram_addr_o = bus.req_addr_i;
                  bus.ram_d_o    = bus.req_wdata_i;
                  w_rd_hs        = (bus.req_wstrb_i == '0);
               end else if (clear_i && !r_inflight) begin
                  w_state_nxt = S_CLEAR;
               end
            end
            default: w_state_nxt = S_READY;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= (INIT_EN != 0) ? S_CLEAR : S_READY;
         r_cnt      <= '0;
         r_inflight <= 1'b0;
         r_occ      <= 2'd0;
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_inflight <= w_rd_hs;
         r_occ      <= r_occ + 2'(w_push) - 2'(w_pop);
         r_wptr     <= r_wptr ^ w_push;
         r_rptr     <= r_rptr ^ w_pop;
      end
   end

   // Read data lands one cycle after the strobe, so capture keys off r_inflight.
   always_ff @(posedge clk_i) begin
      if (w_push) r_buf[r_wptr] <= bus.ram_d_i;
   end
endmodule

// File: tb/tb_iob_ram_sp_be_ctrl.sv
// Directed bench for iob_ram_sp_be_ctrl with a behavioural RAM and a read-response scoreboard.
module tb_iob_ram_sp_be_ctrl;
   localparam int                ADDR_W   = 4;
   localparam int                DATA_W   = 32;
   localparam int                STRB_W   = DATA_W / 8;
   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [DATA_W-1:0] INIT_VAL = '0;

   logic clk_i = 1'b0;
   logic rst_i;
   logic clear_i;
   logic busy_o;

   iob_ram_sp_be_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   iob_ram_sp_be_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_EN(1), .INIT_VAL(INIT_VAL)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .busy_o(busy_o), .bus(bus)
   );

   always #5 clk_i = ~clk_i;

   logic [DATA_W-1:0] ram_mem   [DEPTH];
   logic [DATA_W-1:0] model_mem [DEPTH];
   logic [DATA_W-1:0] sb [$];
   int n_tests = 0;
   int n_fail  = 0;
   int n_beats = 0;
   int n_hs    = 0;
   int streak  = 0;
   int max_streak = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural single-port RAM, 1-cycle read latency.
   always @(posedge clk_i) begin
      if (bus.ram_en_o) begin
         for (int b = 0; b < STRB_W; b++)
            if (bus.ram_we_o[b]) ram_mem[bus.ram_addr_o][8*b +: 8] <= bus.ram_d_o[8*b +: 8];
         bus.ram_d_i <= ram_mem[bus.ram_addr_o];
      end
   end

   // Monitor: record handshakes into the model/scoreboard, check every response beat.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (bus.rvalid_o) begin
            check("rvalid_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
               check("rdata", bus.rdata_o, sb[0]);
               if (bus.rready_i) void'(sb.pop_front());
            end
         end
         if (bus.rvalid_o && bus.rready_i) begin
            n_beats++;
            streak++;
            if (streak > max_streak) max_streak = streak;
         end else begin
            streak = 0;
         end
         if (bus.req_valid_i && bus.req_ready_o) begin
            n_hs++;
            if (bus.req_wstrb_i == '0) sb.push_back(model_mem[bus.req_addr_i]);
            else
               for (int b = 0; b < STRB_W; b++)
                  if (bus.req_wstrb_i[b]) model_mem[bus.req_addr_i][8*b +: 8] = bus.req_wdata_i[8*b +: 8];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic req(input logic [ADDR_W-1:0] a, input logic [STRB_W-1:0] s,
                      input logic [DATA_W-1:0] d, output int waits);
      waits = 0;
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = a;
      bus.req_wstrb_i = s;
      bus.req_wdata_i = d;
      @(negedge clk_i);
      while (!bus.req_ready_o && waits < 40) begin
         @(negedge clk_i);
         waits++;
      end
      if (waits >= 40) check("req_timeout", bus.req_ready_o, 1'b1);
      cyc();
      bus.req_valid_i = 1'b0;
   endtask

   task automatic sweep_check();
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk_i);
         check("sweep_busy", busy_o, 1'b1);
         check("sweep_en", bus.ram_en_o, 1'b1);
         check("sweep_we", bus.ram_we_o, {STRB_W{1'b1}});
         check("sweep_addr", bus.ram_addr_o, i);
         check("sweep_d", bus.ram_d_o, INIT_VAL);
         check("sweep_ready", bus.req_ready_o, 1'b0);
      end
      @(negedge clk_i);
      check("sweep_done_busy", busy_o, 1'b0);
      check("sweep_done_ready", bus.req_ready_o, 1'b1);
      check("sweep_done_en", bus.ram_en_o, 1'b0);
      for (int a = 0; a < DEPTH; a++) model_mem[a] = INIT_VAL;
   endtask

   initial begin
      int w;
      int n;
      int beats0;
      int hs0;
      rst_i = 1'b1;
      clear_i = 1'b0;
      bus.req_valid_i = 1'b0;
      bus.req_addr_i  = '0;
      bus.req_wstrb_i = '0;
      bus.req_wdata_i = '0;
      bus.rready_i    = 1'b1;
      for (int a = 0; a < DEPTH; a++) model_mem[a] = INIT_VAL;

      // 1: reset values, then the power-on sweep
      cyc(); cyc();
      @(negedge clk_i);
      check("rst_busy", busy_o, 1'b1);
      check("rst_ram_en", bus.ram_en_o, 1'b0);
      check("rst_ram_we", bus.ram_we_o, '0);
      check("rst_ram_addr", bus.ram_addr_o, '0);
      check("rst_req_ready", bus.req_ready_o, 1'b0);
      check("rst_rvalid", bus.rvalid_o, 1'b0);
      check("rst_rdata", bus.rdata_o, '0);
      cyc();
      rst_i = 1'b0;
      sweep_check();
      cyc();

      // 2: full write, partial write, read-back
      req(4'd3, 4'hF, 32'hDEADBEEF, w);
      req(4'd3, 4'h2, 32'h0000AA00, w);
      req(4'd3, 4'h0, 32'h0, w);
      cyc();
      @(negedge clk_i);
      check("t2_rvalid", bus.rvalid_o, 1'b1);
      check("t2_rdata", bus.rdata_o, 32'hDEADAAEF);
      cyc(); cyc();

      // 3: streaming reads at full rate
      for (int i = 0; i < 8; i++) req(4'(i), 4'hF, 32'hA5000000 ^ {4{8'(i)}}, w);
      cyc(); cyc();
      beats0 = n_beats;
      max_streak = 0;
      for (int i = 0; i < 8; i++) begin
         req(4'(i), 4'h0, 32'h0, w);
         check("t3_no_bubble", w, 0);
      end
      cyc(); cyc(); cyc();
      check("t3_beats", n_beats - beats0, 8);
      check("t3_consecutive", max_streak, 8);
      check("t3_sb_empty", sb.size(), 0);

      // 4: backpressure fills the buffer, then drains in order
      bus.rready_i = 1'b0;
      hs0 = n_hs;
      beats0 = n_beats;
      req(4'd6, 4'h0, 32'h0, w);
      check("t4_acc0", w, 0);
      req(4'd1, 4'h0, 32'h0, w);
      check("t4_acc1", w, 0);
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = 4'd2;
      bus.req_wstrb_i = 4'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("t4_stall_ready", bus.req_ready_o, 1'b0);
         check("t4_stall_rvalid", bus.rvalid_o, 1'b1);
         cyc();
      end
      check("t4_accepted", n_hs - hs0, 2);
      bus.rready_i = 1'b1;
      req(4'd2, 4'h0, 32'h0, w);
      check("t4_release_ready", w, 0);
      cyc(); cyc(); cyc();
      check("t4_beats", n_beats - beats0, 3);
      check("t4_sb_empty", sb.size(), 0);

      // 5: clear ignored with a read in flight, honoured when idle
      req(4'd5, 4'h0, 32'h0, w);
      clear_i = 1'b1;
      cyc();
      clear_i = 1'b0;
      @(negedge clk_i);
      check("t5_clear_ignored", busy_o, 1'b0);
      cyc(); cyc(); cyc();
      check("t5_sb_empty", sb.size(), 0);
      clear_i = 1'b1;
      cyc();
      clear_i = 1'b0;
      sweep_check();
      cyc();
      req(4'd5, 4'h0, 32'h0, w);
      cyc();
      @(negedge clk_i);
      check("t5_rvalid", bus.rvalid_o, 1'b1);
      check("t5_init_val", bus.rdata_o, INIT_VAL);
      cyc(); cyc();

      // 6: reset in the middle of a sweep restarts it from address 0
      clear_i = 1'b1;
      cyc();
      clear_i = 1'b0;
      n = 0;
      @(negedge clk_i);
      while (!(busy_o && bus.ram_addr_o == 4'd9) && n < 40) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 40) check("t6_reach_addr9", bus.ram_addr_o, 4'd9);
      rst_i = 1'b1;
      #1;
      check("t6_rst_busy", busy_o, 1'b1);
      check("t6_rst_ram_en", bus.ram_en_o, 1'b0);
      check("t6_rst_ram_we", bus.ram_we_o, '0);
      check("t6_rst_ready", bus.req_ready_o, 1'b0);
      cyc();
      rst_i = 1'b0;
      sweep_check();
      cyc();
      req(4'd9, 4'h0, 32'h0, w);
      cyc(); cyc(); cyc();
      check("t6_sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
